iq_phase_det: RTL and testbench

Vectoring-mode CORDIC phase/magnitude detector for the SDR receive path: accepts signed 17-bit I/Q samples and returns the sample phase in the same 32-bit unsigned angle format the NCO accumulates (32'h40000000 = Pi/2), plus magnitude and sample-to-sample phase increment. It is the inverse of the NCO: feeding NCO cos/sin back in recovers its angle_incr on `freq`. Fully pipelined, one sample per clock, with valid qualification.

---
 rtl/sdr_pkg.sv | 40 ++++
 rtl/cordic_vec_stage.sv | 49 ++++
 rtl/iq_phase_det.sv | 114 +++++++++++
 tb/tb_iq_phase_det.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdr_pkg.sv
// Shared SDR receive-path constants: sample/angle widths and the CORDIC arctangent table.
package sdr_pkg;

  localparam int unsigned ANGLE_W  = 32;
  localparam int unsigned SAMPLE_W = 17;
  localparam int unsigned INT_W    = 19;
  localparam int unsigned MAG_W    = 18;
  localparam int unsigned ATAN_N   = 20;

  localparam logic [ANGLE_W-1:0] PI_HALF  = 32'h4000_0000;
  localparam logic [ANGLE_W-1:0] ANGLE_PI = 32'h8000_0000;

  // round(atan(2^-k) / (2*Pi) * 2^32), k = 0..19
  function automatic logic [ANGLE_W-1:0] atan_lut(input int unsigned k);
    case (k)
      0:       return 32'h2000_0000;
      1:       return 32'h12E4_051E;
      2:       return 32'h09FB_385B;
      3:       return 32'h0511_11D4;
      4:       return 32'h028B_0D43;
      5:       return 32'h0145_D7E1;
      6:       return 32'h00A2_F61E;
      7:       return 32'h0051_7C55;
      8:       return 32'h0028_BE53;
      9:       return 32'h0014_5F2F;
      10:      return 32'h000A_2F98;
      11:      return 32'h0005_17CC;
      12:      return 32'h0002_8BE6;
      13:      return 32'h0001_45F3;
      14:      return 32'h0000_A2FA;
      15:      return 32'h0000_517D;
      16:      return 32'h0000_28BE;
      17:      return 32'h0000_145F;
      18:      return 32'h0000_0A30;
      19:      return 32'h0000_0518;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// One registered vectoring-mode CORDIC iteration: rotates (x, y) toward the +x axis
// and accumulates the applied rotation into z.
module cordic_vec_stage
  import sdr_pkg::*;
#(
  parameter int unsigned SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [INT_W-1:0] x,
  input  logic signed [INT_W-1:0] y,
  input  logic [ANGLE_W-1:0]      z,
  input  logic                    valid,
  input  logic                    zero,
  output logic signed [INT_W-1:0] x_q,
  output logic signed [INT_W-1:0] y_q,
  output logic [ANGLE_W-1:0]      z_q,
  output logic                    valid_q,
  output logic                    zero_q
);

  localparam logic [ANGLE_W-1:0] ATAN_K = atan_lut(SHIFT);

  logic signed [INT_W-1:0] x_sh;
  logic signed [INT_W-1:0] y_sh;

  assign x_sh = x >>> SHIFT;
  assign y_sh = y >>> SHIFT;

  always_ff @(posedge clk) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= valid;
  end

  // Rotate clockwise while y is non-negative, counter-clockwise otherwise.
  always_ff @(posedge clk) begin
    zero_q <= zero;
    if (!y[INT_W-1]) begin
      x_q <= x + y_sh;
      y_q <= y - x_sh;
      z_q <= z + ATAN_K;
    end else begin
      x_q <= x - y_sh;
      y_q <= y + x_sh;
      z_q <= z - ATAN_K;
    end
  end

endmodule

// File: rtl/iq_phase_det.sv
// Pipelined CORDIC phase/magnitude detector: I/Q sample in, NCO-format phase, magnitude
// and sample-to-sample phase increment out, STAGES+2 clocks later.
module iq_phase_det
  import sdr_pkg::*;
#(
  parameter int unsigned STAGES = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic signed [SAMPLE_W-1:0] i_in,
  input  logic signed [SAMPLE_W-1:0] q_in,
  output logic                       out_valid,
  output logic [ANGLE_W-1:0]         phase,
  output logic [MAG_W-1:0]           mag,
  output logic [ANGLE_W-1:0]         freq
);

  logic signed [INT_W-1:0] i_ext;
  logic signed [INT_W-1:0] q_ext;

  logic signed [INT_W-1:0] fold_x;
  logic signed [INT_W-1:0] fold_y;
  logic [ANGLE_W-1:0]      fold_z;
  logic                    fold_valid;
  logic                    fold_zero;

  logic signed [INT_W-1:0] xs [STAGES+1];
  logic signed [INT_W-1:0] ys [STAGES+1];
  logic [ANGLE_W-1:0]      zs [STAGES+1];
  logic                    vs [STAGES+1];
  logic                    zf [STAGES+1];

  logic [ANGLE_W-1:0] phase_c;
  logic [MAG_W-1:0]   mag_c;
  logic               unused_last;

  assign i_ext = INT_W'(i_in);
  assign q_ext = INT_W'(q_in);

  always_ff @(posedge clk) begin
    if (rst) fold_valid <= 1'b0;
    else     fold_valid <= in_valid;
  end

  // Fold the left half-plane onto the right; 19-bit width keeps -(-65536) exact.
  always_ff @(posedge clk) begin
    fold_zero <= (i_in == '0) && (q_in == '0);
    if (i_in[SAMPLE_W-1]) begin
      fold_x <= -i_ext;
      fold_y <= -q_ext;
      fold_z <= ANGLE_PI;
    end else begin
      fold_x <= i_ext;
      fold_y <= q_ext;
      fold_z <= '0;
    end
  end

  assign xs[0] = fold_x;
  assign ys[0] = fold_y;
  assign zs[0] = fold_z;
  assign vs[0] = fold_valid;
  assign zf[0] = fold_zero;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    cordic_vec_stage #(
      .SHIFT(k)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .x      (xs[k]),
      .y      (ys[k]),
      .z      (zs[k]),
      .valid  (vs[k]),
      .zero   (zf[k]),
      .x_q    (xs[k+1]),
      .y_q    (ys[k+1]),
      .z_q    (zs[k+1]),
      .valid_q(vs[k+1]),
      .zero_q (zf[k+1])
    );
  end

  // Residual y and the x sign bit are not needed once the vector sits on the +x axis.
  assign unused_last = ^{ys[STAGES], xs[STAGES][INT_W-1]};

  always_comb begin
    phase_c = zs[STAGES];
    mag_c   = xs[STAGES][MAG_W-1:0];
    if (zf[STAGES]) begin
      phase_c = '0;
      mag_c   = '0;
    end
  end

  // phase only moves on valid outputs, so it doubles as the previous valid phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      phase     <= '0;
      mag       <= '0;
      freq      <= '0;
    end else begin
      out_valid <= vs[STAGES];
      if (vs[STAGES]) begin
        phase <= phase_c;
        mag   <= mag_c;
        freq  <= phase_c - phase;
      end
    end
  end

endmodule

// File: tb/tb_iq_phase_det.sv
// Self-checking bench for iq_phase_det: real-math model feeds a scoreboard queue,
// each scenario task compares DUT outputs against it as they emerge.
module tb_iq_phase_det;

  localparam int unsigned STAGES  = 16;
  localparam int unsigned LAT     = STAGES + 2;
  localparam longint      PH_TOL  = 65536;
  localparam longint      FR_TOL  = 131072;
  localparam real         TWO_PI  = 6.283185307179586;
  localparam real         K_GAIN  = 1.646760258;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic signed [16:0] i_in;
  logic signed [16:0] q_in;
  logic               out_valid;
  logic [31:0]        phase;
  logic [17:0]        mag;
  logic [31:0]        freq;

  iq_phase_det #(.STAGES(STAGES)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .i_in     (i_in),
    .q_in     (q_in),
    .out_valid(out_valid),
    .phase    (phase),
    .mag      (mag),
    .freq     (freq)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        zero;
    logic [31:0] ph;
    logic [31:0] fr;
    int          mag;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_prev = '0;
  int          checks = 0;
  int          passed = 0;

  function automatic longint ang_err(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] diff;
    longint d;
    diff = a - b;
    d = longint'($signed(diff));
    return (d < 0) ? -d : d;
  endfunction

  function automatic logic [31:0] model_phase(input int i, input int q);
    real a;
    longint r;
    a = $atan2(real'(q), real'(i));
    if (a < 0.0) a = a + TWO_PI;
    r = longint'(a / TWO_PI * 4294967296.0);
    return r[31:0];
  endfunction

  function automatic int model_mag(input int i, input int q);
    return int'(K_GAIN * $sqrt(real'(i) * real'(i) + real'(q) * real'(q)));
  endfunction

  function automatic int mag_tol(input int m);
    return (m + 999) / 1000;
  endfunction

  function automatic int abs_i(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Drive one input cycle; valid samples push their expected result.
  task automatic drive(input logic v, input int i, input int q);
    exp_t e;
    in_valid = v;
    i_in     = 17'(i);
    q_in     = 17'(q);
    if (v) begin
      e.zero = (i == 0) && (q == 0);
      e.ph   = e.zero ? 32'h0 : model_phase(i, q);
      e.mag  = e.zero ? 0 : model_mag(i, q);
      e.fr   = e.ph - model_prev;
      e.due  = cyc + LAT;
      model_prev = e.ph;
      sb.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 0, 0);
    repeat (3) @(negedge clk);
    checks += 4;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
    if (phase !== 32'h0)    $display("FAIL reset_phase: got %h want 0", phase); else passed++;
    if (mag !== 18'h0)      $display("FAIL reset_mag: got %h want 0", mag); else passed++;
    if (freq !== 32'h0)     $display("FAIL reset_freq: got %h want 0", freq); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_points();
    int ti[6] = '{20000, 0, -20000, 0, -65536, 65535};
    int tq[6] = '{0, 20000, 0, -20000, -65536, 65535};
    exp_t e;
    for (int n = 0; n < 6 + LAT + 8; n++) begin
      @(negedge clk);
      if (out_valid) begin
        checks++;
        if (sb.size() == 0) $display("FAIL points_unexpected: out_valid at cycle %0d", cyc);
        else begin
          e = sb.pop_front();
          if (cyc !== e.due) $display("FAIL points_latency: cycle %0d want %0d", cyc, e.due); else passed++;
          checks += 3;
          if (ang_err(phase, e.ph) > PH_TOL) $display("FAIL points_phase: got %h want %h", phase, e.ph); else passed++;
          if (abs_i(int'(mag) - e.mag) > mag_tol(e.mag)) $display("FAIL points_mag: got %0d want %0d", mag, e.mag); else passed++;
          if (ang_err(freq, e.fr) > FR_TOL) $display("FAIL points_freq: got %h want %h", freq, e.fr); else passed++;
        end
      end
      if (n < 6) drive(1'b1, ti[n], tq[n]);
      else       drive(1'b0, 0, 0);
    end
    checks++;
    if (sb.size() != 0) begin $display("FAIL points_drain: %0d outputs missing", sb.size()); sb.delete(); end
    else passed++;
  endtask

  task automatic test_zero();
    exp_t e;
    for (int n = 0; n < 1 + LAT + 8; n++) begin
      @(negedge clk);
      if (out_valid) begin
        checks++;
        if (sb.size() == 0) $display("FAIL zero_unexpected: out_valid at cycle %0d", cyc);
        else begin
          e = sb.pop_front();
          if (cyc !== e.due) $display("FAIL zero_latency: cycle %0d want %0d", cyc, e.due); else passed++;
          checks += 3;
          if (phase !== 32'h0) $display("FAIL zero_phase: got %h want 0", phase); else passed++;
          if (mag !== 18'h0) $display("FAIL zero_mag: got %0d want 0", mag); else passed++;
          if (ang_err(freq, e.fr) > FR_TOL) $display("FAIL zero_freq: got %h want %h", freq, e.fr); else passed++;
        end
      end
      if (n == 0) drive(1'b1, 0, 0);
      else        drive(1'b0, 0, 0);
    end
    checks++;
    if (sb.size() != 0) begin $display("FAIL zero_drain: %0d outputs missing", sb.size()); sb.delete(); end
    else passed++;
  endtask

  task automatic test_nco_loopback();
    localparam int N = 300;
    logic [31:0] acc = '0;
    real a;
    exp_t e;
    for (int n = 0; n < N + LAT + 8; n++) begin
      @(negedge clk);
      if (out_valid) begin
        checks++;
        if (sb.size() == 0) $display("FAIL nco_unexpected: out_valid at cycle %0d", cyc);
        else begin
          e = sb.pop_front();
          if (cyc !== e.due) $display("FAIL nco_latency: cycle %0d want %0d", cyc, e.due); else passed++;
          checks += 3;
          if (ang_err(phase, e.ph) > PH_TOL) $display("FAIL nco_phase: got %h want %h", phase, e.ph); else passed++;
          if (abs_i(int'(mag) - e.mag) > mag_tol(e.mag)) $display("FAIL nco_mag: got %0d want %0d", mag, e.mag); else passed++;
          if (ang_err(freq, e.fr) > FR_TOL) $display("FAIL nco_freq: got %h want %h", freq, e.fr); else passed++;
        end
      end
      if (n < N) begin
        a = real'(acc) / 4294967296.0 * TWO_PI;
        drive(1'b1, int'(30000.0 * $cos(a)), int'(30000.0 * $sin(a)));
        acc = acc + 32'h0100_0000;
      end else begin
        drive(1'b0, 0, 0);
      end
    end
    checks++;
    if (sb.size() != 0) begin $display("FAIL nco_drain: %0d outputs missing", sb.size()); sb.delete(); end
    else passed++;
  endtask

  task automatic test_valid_gaps();
    int pat[5] = '{1, 0, 0, 1, 1};
    real a;
    exp_t e;
    for (int n = 0; n < 5 + LAT + 8; n++) begin
      @(negedge clk);
      if (out_valid) begin
        checks++;
        if (sb.size() == 0) $display("FAIL gaps_unexpected: out_valid at cycle %0d", cyc);
        else begin
          e = sb.pop_front();
          if (cyc !== e.due) $display("FAIL gaps_latency: cycle %0d want %0d", cyc, e.due); else passed++;
          checks += 3;
          if (ang_err(phase, e.ph) > PH_TOL) $display("FAIL gaps_phase: got %h want %h", phase, e.ph); else passed++;
          if (abs_i(int'(mag) - e.mag) > mag_tol(e.mag)) $display("FAIL gaps_mag: got %0d want %0d", mag, e.mag); else passed++;
          if (ang_err(freq, e.fr) > FR_TOL) $display("FAIL gaps_freq: got %h want %h", freq, e.fr); else passed++;
        end
      end
      if (n < 5) begin
        a = real'(n) * 0.7 + 0.3;
        drive(pat[n] != 0, int'(25000.0 * $cos(a)), int'(25000.0 * $sin(a)));
      end else begin
        drive(1'b0, 0, 0);
      end
    end
    checks++;
    if (sb.size() != 0) begin $display("FAIL gaps_drain: %0d outputs missing", sb.size()); sb.delete(); end
    else passed++;
  endtask

  task automatic test_reset_midstream();
    exp_t e;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      drive(1'b1, 15000 - n * 3000, 8000 + n * 700);
    end
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 0, 0);
    sb.delete();
    model_prev = '0;
    @(negedge clk);
    checks += 4;
    if (out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b want 0", out_valid); else passed++;
    if (phase !== 32'h0)    $display("FAIL midrst_phase: got %h want 0", phase); else passed++;
    if (mag !== 18'h0)      $display("FAIL midrst_mag: got %h want 0", mag); else passed++;
    if (freq !== 32'h0)     $display("FAIL midrst_freq: got %h want 0", freq); else passed++;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, -12000, 5000);
    for (int n = 0; n < LAT + 12; n++) begin
      @(negedge clk);
      drive(1'b0, 0, 0);
      if (out_valid) begin
        checks++;
        if (sb.size() == 0) $display("FAIL midrst_unexpected: out_valid at cycle %0d", cyc);
        else begin
          e = sb.pop_front();
          if (cyc !== e.due) $display("FAIL midrst_latency: cycle %0d want %0d", cyc, e.due); else passed++;
          checks += 4;
          if (ang_err(phase, e.ph) > PH_TOL) $display("FAIL midrst_phase_out: got %h want %h", phase, e.ph); else passed++;
          if (abs_i(int'(mag) - e.mag) > mag_tol(e.mag)) $display("FAIL midrst_mag_out: got %0d want %0d", mag, e.mag); else passed++;
          if (ang_err(freq, e.fr) > FR_TOL) $display("FAIL midrst_freq_out: got %h want %h", freq, e.fr); else passed++;
          if (freq !== phase) $display("FAIL midrst_freq_eq_phase: freq %h phase %h", freq, phase); else passed++;
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin $display("FAIL midrst_drain: %0d outputs missing", sb.size()); sb.delete(); end
    else passed++;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    i_in     = '0;
    q_in     = '0;
    test_reset();
    test_points();
    test_zero();
    test_nco_loopback();
    test_valid_gaps();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
